uart_frame_link: RTL and testbench

// Framing layer between the core's word-level I/O and the byte-level uart_comm block.
// TX: one word plus byte count goes in, and it is serialised into a framed byte stream

---
 rtl/uart_frame_link.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_frame_link.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_link.sv
// uart_frame_link: framing layer between word-level core I/O and the byte-level uart_comm block.
// Frame on the wire: SYNC_BYTE, LEN, LEN payload bytes (byte 0 first), CSUM = LEN ^ payload bytes.
// Ports:
//   CLK, RST_N                       clock, asynchronous active-low reset
//   tx_valid/tx_ready/tx_data/tx_len core -> link word to frame and send
//   rx_valid/rx_ready/rx_data/rx_len link -> core de-framed, checked word
//   err_count                        saturating count of dropped RX frames
//   uart_send_flag/data/ack/sendable byte write handshake towards uart_comm
//   uart_recv_flag/data/ack/receivable byte read handshake from uart_comm
module uart_frame_link #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 8,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [8*MAX_LEN-1:0]   tx_data,
  input  logic [3:0]             tx_len,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [8*MAX_LEN-1:0]   rx_data,
  output logic [3:0]             rx_len,
  output logic [7:0]             err_count,
  output logic                   uart_send_flag,
  output logic [7:0]             uart_send_data,
  input  logic                   uart_send_ack,
  input  logic                   uart_sendable,
  output logic                   uart_recv_flag,
  input  logic [7:0]             uart_recv_data,
  input  logic                   uart_recv_ack,
  input  logic                   uart_receivable
);

  localparam int unsigned W       = 8 * MAX_LEN;
  localparam int unsigned TW      = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]  LEN_MAX = 4'(MAX_LEN);

  localparam logic [2:0] TX_IDLE = 3'd0;
  localparam logic [2:0] TX_SYNC = 3'd1;
  localparam logic [2:0] TX_LEN  = 3'd2;
  localparam logic [2:0] TX_DATA = 3'd3;
  localparam logic [2:0] TX_CSUM = 3'd4;

  localparam logic [2:0] RX_HUNT = 3'd0;
  localparam logic [2:0] RX_LEN  = 3'd1;
  localparam logic [2:0] RX_DATA = 3'd2;
  localparam logic [2:0] RX_CSUM = 3'd3;
  localparam logic [2:0] RX_HOLD = 3'd4;

  logic [2:0]    tx_state, tx_state_n;
  logic [W-1:0]  tx_buf, tx_buf_n;
  logic [3:0]    tx_cnt, tx_cnt_n, tx_idx, tx_idx_n;
  logic [7:0]    tx_csum, tx_csum_n, tx_byte, tx_cur;
  logic          tx_ready_n, send_flag_n;
  logic [7:0]    send_data_n;

  logic [2:0]    rx_state, rx_state_n;
  logic [W-1:0]  rx_asm, rx_asm_n, rx_data_n;
  logic [3:0]    rx_cnt, rx_cnt_n, rx_idx, rx_idx_n, rx_len_n;
  logic [7:0]    rx_csum, rx_csum_n, err_count_n;
  logic [TW-1:0] rx_tmr, rx_tmr_n;
  logic          rx_drop, rx_drop_n, rx_valid_n, recv_flag_n, rx_err, rx_in_frame;

  // TX: next-state and byte handshake
  always_comb begin
    tx_state_n  = tx_state;
    tx_buf_n    = tx_buf;
    tx_cnt_n    = tx_cnt;
    tx_idx_n    = tx_idx;
    tx_csum_n   = tx_csum;
    send_flag_n = uart_send_flag;
    send_data_n = uart_send_data;
    tx_byte     = 8'h00;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (tx_idx == 4'(i)) tx_byte = tx_buf[8*i +: 8];
    end
    case (tx_state)
      TX_SYNC: tx_cur = SYNC_BYTE;
      TX_LEN:  tx_cur = {4'h0, tx_cnt};
      TX_DATA: tx_cur = tx_byte;
      default: tx_cur = tx_csum;
    endcase
    if (tx_state == TX_IDLE) begin
      // Out-of-range lengths are accepted and dropped without sending anything
      if (tx_valid && tx_ready && tx_len != 4'd0 && tx_len <= LEN_MAX) begin
        tx_buf_n   = tx_data;
        tx_cnt_n   = tx_len;
        tx_state_n = TX_SYNC;
      end
    end else if (uart_send_flag) begin
      if (uart_send_ack) begin
        send_flag_n = 1'b0;
        case (tx_state)
          TX_SYNC: tx_state_n = TX_LEN;
          TX_LEN: begin
            tx_csum_n  = {4'h0, tx_cnt};
            tx_idx_n   = 4'd0;
            tx_state_n = TX_DATA;
          end
          TX_DATA: begin
            tx_csum_n = tx_csum ^ tx_byte;
            tx_idx_n  = tx_idx + 4'd1;
            if (tx_idx == tx_cnt - 4'd1) tx_state_n = TX_CSUM;
          end
          default: tx_state_n = TX_IDLE;
        endcase
      end
    end else if (uart_sendable) begin
      // Flag was low for at least the cycle after the previous ack
      send_flag_n = 1'b1;
      send_data_n = tx_cur;
    end
    tx_ready_n = (tx_state_n == TX_IDLE);
  end

  // RX: next-state, byte handshake, timeout and error counting
  always_comb begin
    rx_state_n  = rx_state;
    rx_asm_n    = rx_asm;
    rx_cnt_n    = rx_cnt;
    rx_idx_n    = rx_idx;
    rx_csum_n   = rx_csum;
    rx_tmr_n    = rx_tmr;
    rx_drop_n   = rx_drop;
    rx_valid_n  = rx_valid;
    rx_data_n   = rx_data;
    rx_len_n    = rx_len;
    recv_flag_n = uart_recv_flag;
    rx_err      = 1'b0;
    rx_in_frame = (rx_state == RX_LEN) || (rx_state == RX_DATA) || (rx_state == RX_CSUM);
    if (rx_in_frame) rx_tmr_n = rx_tmr + TW'(1);
    if (uart_recv_flag && uart_recv_ack) begin
      recv_flag_n = 1'b0;
      rx_tmr_n    = '0;
      if (rx_drop) begin
        // Byte requested before a timeout: completed but thrown away
        rx_drop_n = 1'b0;
      end else begin
        case (rx_state)
          RX_HUNT: if (uart_recv_data == SYNC_BYTE) rx_state_n = RX_LEN;
          RX_LEN: begin
            if (uart_recv_data == 8'h00 || uart_recv_data > 8'(MAX_LEN)) begin
              rx_err     = 1'b1;
              rx_state_n = RX_HUNT;
            end else begin
              rx_cnt_n   = uart_recv_data[3:0];
              rx_idx_n   = 4'd0;
              rx_csum_n  = uart_recv_data;
              rx_asm_n   = '0;
              rx_state_n = RX_DATA;
            end
          end
          RX_DATA: begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (rx_idx == 4'(i)) rx_asm_n[8*i +: 8] = uart_recv_data;
            end
            rx_csum_n = rx_csum ^ uart_recv_data;
            rx_idx_n  = rx_idx + 4'd1;
            if (rx_idx == rx_cnt - 4'd1) rx_state_n = RX_CSUM;
          end
          RX_CSUM: begin
            if (uart_recv_data == rx_csum) begin
              rx_valid_n = 1'b1;
              rx_data_n  = rx_asm;
              rx_len_n   = rx_cnt;
              rx_state_n = RX_HOLD;
            end else begin
              rx_err     = 1'b1;
              rx_state_n = RX_HUNT;
            end
          end
          default: ;
        endcase
      end
    end else if (rx_in_frame && rx_tmr == TW'(TIMEOUT - 1)) begin
      rx_err     = 1'b1;
      rx_tmr_n   = '0;
      rx_drop_n  = uart_recv_flag;
      rx_state_n = RX_HUNT;
    end
    if (rx_state == RX_HOLD && rx_valid && rx_ready) begin
      rx_valid_n = 1'b0;
      rx_state_n = RX_HUNT;
    end
    // No reads while holding a word: backpressure stays in uart_comm
    if (!uart_recv_flag && uart_receivable && rx_state != RX_HOLD) recv_flag_n = 1'b1;
    err_count_n = (rx_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state       <= TX_IDLE;
      tx_buf         <= '0;
      tx_cnt         <= 4'd0;
      tx_idx         <= 4'd0;
      tx_csum        <= 8'h00;
      tx_ready       <= 1'b0;
      uart_send_flag <= 1'b0;
      uart_send_data <= 8'h00;
      rx_state       <= RX_HUNT;
      rx_asm         <= '0;
      rx_cnt         <= 4'd0;
      rx_idx         <= 4'd0;
      rx_csum        <= 8'h00;
      rx_tmr         <= '0;
      rx_drop        <= 1'b0;
      rx_valid       <= 1'b0;
      rx_data        <= '0;
      rx_len         <= 4'd0;
      uart_recv_flag <= 1'b0;
      err_count      <= 8'h00;
    end else begin
      tx_state       <= tx_state_n;
      tx_buf         <= tx_buf_n;
      tx_cnt         <= tx_cnt_n;
      tx_idx         <= tx_idx_n;
      tx_csum        <= tx_csum_n;
      tx_ready       <= tx_ready_n;
      uart_send_flag <= send_flag_n;
      uart_send_data <= send_data_n;
      rx_state       <= rx_state_n;
      rx_asm         <= rx_asm_n;
      rx_cnt         <= rx_cnt_n;
      rx_idx         <= rx_idx_n;
      rx_csum        <= rx_csum_n;
      rx_tmr         <= rx_tmr_n;
      rx_drop        <= rx_drop_n;
      rx_valid       <= rx_valid_n;
      rx_data        <= rx_data_n;
      rx_len         <= rx_len_n;
      uart_recv_flag <= recv_flag_n;
      err_count      <= err_count_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_link.sv
// tb_uart_frame_link: scoreboard bench for uart_frame_link with behavioural uart_comm models.
// Expected TX bytes and RX words are computed from the frame format when stimulus is issued.
module tb_uart_frame_link;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned TMO     = 300;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic        clk, rst_n;
  logic        tx_valid, tx_ready;
  logic [63:0] tx_data;
  logic [3:0]  tx_len;
  logic        rx_valid, rx_ready;
  logic [63:0] rx_data;
  logic [3:0]  rx_len;
  logic [7:0]  err_count;
  logic        uart_send_flag, uart_send_ack, uart_sendable;
  logic [7:0]  uart_send_data;
  logic        uart_recv_flag, uart_recv_ack, uart_receivable;
  logic [7:0]  uart_recv_data;

  uart_frame_link #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST_N(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_len(tx_len),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_len(rx_len),
    .err_count(err_count),
    .uart_send_flag(uart_send_flag), .uart_send_data(uart_send_data),
    .uart_send_ack(uart_send_ack), .uart_sendable(uart_sendable),
    .uart_recv_flag(uart_recv_flag), .uart_recv_data(uart_recv_data),
    .uart_recv_ack(uart_recv_ack), .uart_receivable(uart_receivable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  len;
    logic [63:0] data;
  } rx_item_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_err = 0;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_feed[$];
  rx_item_t    rx_exp[$];
  bit          block_send = 0;
  bit          rx_hold    = 0;
  bit          rx_stall   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // uart_comm TX side: random ack latency, protocol checks, byte scoreboard
  initial begin : tx_uart
    int         lat;
    bit         prev_flag, prev_sendable;
    logic [7:0] held;
    uart_send_ack = 1'b0; uart_sendable = 1'b0;
    prev_flag = 0; prev_sendable = 0; lat = 0; held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        uart_send_ack = 1'b0; uart_sendable = 1'b0; prev_flag = 0; prev_sendable = 0;
      end else begin
        if (uart_send_ack) begin
          uart_send_ack = 1'b0;
          chk("tx_flag_drop_after_ack", 64'(uart_send_flag), 64'd0);
        end else if (uart_send_flag) begin
          if (!prev_flag) begin
            chk("tx_flag_rise_needs_sendable", 64'(prev_sendable), 64'd1);
            held = uart_send_data;
            lat  = $urandom_range(0, 3);
          end else begin
            chk("tx_data_stable", 64'(uart_send_data), 64'(held));
          end
          if (lat == 0) begin
            uart_send_ack = 1'b1;
            if (tx_exp.size() == 0) fail_now($sformatf("tx_byte unexpected %0h", uart_send_data));
            else chk("tx_byte", 64'(uart_send_data), 64'(tx_exp.pop_front()));
          end else begin
            lat--;
          end
        end
        prev_flag     = uart_send_flag;
        uart_sendable = block_send ? 1'b0 : ($urandom_range(0, 3) != 0);
        prev_sendable = uart_sendable;
      end
    end
  end

  // uart_comm RX side: serves bytes from rx_feed, garbage data outside the ack cycle
  initial begin : rx_uart
    int  lat;
    bit  prev_flag, prev_recv;
    uart_recv_ack = 1'b0; uart_receivable = 1'b0; uart_recv_data = 8'h00;
    prev_flag = 0; prev_recv = 0; lat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        uart_recv_ack = 1'b0; uart_receivable = 1'b0; prev_flag = 0; prev_recv = 0;
      end else begin
        uart_recv_data = 8'($urandom);
        if (uart_recv_ack) begin
          uart_recv_ack = 1'b0;
          chk("rx_flag_drop_after_ack", 64'(uart_recv_flag), 64'd0);
        end else if (uart_recv_flag) begin
          if (!prev_flag) begin
            chk("rx_flag_rise_needs_receivable", 64'(prev_recv), 64'd1);
            lat = $urandom_range(0, 3);
          end
          if (!rx_stall) begin
            if (lat == 0) begin
              uart_recv_ack  = 1'b1;
              uart_recv_data = (rx_feed.size() != 0) ? rx_feed.pop_front() : 8'h00;
            end else begin
              lat--;
            end
          end
        end
        prev_flag       = uart_recv_flag;
        uart_receivable = (rx_feed.size() != 0);
        prev_recv       = uart_receivable;
      end
    end
  end

  // Core RX consumer: random ready, pops the scoreboard on each handshake
  initial begin : rx_core
    bit       took;
    rx_item_t it;
    rx_ready = 1'b0; took = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_ready = 1'b0; took = 0;
      end else begin
        if (took) begin
          chk("rx_valid_drop_after_take", 64'(rx_valid), 64'd0);
          took = 0;
        end
        rx_ready = rx_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (rx_valid && rx_ready) begin
          if (rx_exp.size() == 0) begin
            fail_now($sformatf("rx_word unexpected len=%0d data=%0h", rx_len, rx_data));
          end else begin
            it = rx_exp.pop_front();
            chk("rx_len", 64'(rx_len), 64'(it.len));
            chk("rx_data", rx_data, it.data);
          end
          took = 1;
        end
      end
    end
  end

  // Expected wire bytes for one word: SYNC, LEN, payload, XOR checksum
  task automatic push_tx_frame(input logic [63:0] d, input logic [3:0] len);
    logic [7:0] cs, b;
    tx_exp.push_back(SYNC);
    tx_exp.push_back({4'h0, len});
    cs = {4'h0, len};
    for (int i = 0; i < int'(len); i++) begin
      b = d[8*i +: 8];
      tx_exp.push_back(b);
      cs = cs ^ b;
    end
    tx_exp.push_back(cs);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_word(input logic [63:0] d, input logic [3:0] len);
    tx_valid = 1'b1; tx_data = d; tx_len = len;
    for (int k = 0; k < 5000; k++) begin
      if (tx_ready) begin
        if (len != 4'd0 && int'(len) <= int'(MAX_LEN)) push_tx_frame(d, len);
        @(negedge clk);
        tx_valid = 1'b0; tx_data = {$urandom, $urandom}; tx_len = 4'($urandom);
        return;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    fail_now("tx_accept_timeout");
  endtask

  // kind 0: good frame, 1: corrupted checksum, 2: bad length (SYNC, LEN only)
  task automatic feed_frame(input logic [63:0] d, input int len, input int kind, input int junk);
    logic [7:0]  cs, b;
    logic [63:0] m;
    rx_item_t    it;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      rx_feed.push_back(b);
    end
    rx_feed.push_back(SYNC);
    rx_feed.push_back(8'(len));
    if (kind == 2) begin
      exp_err++;
      return;
    end
    cs = 8'(len);
    m  = 64'd0;
    for (int i = 0; i < len; i++) begin
      b = d[8*i +: 8];
      rx_feed.push_back(b);
      cs = cs ^ b;
      m[8*i +: 8] = b;
    end
    if (kind == 1) begin
      rx_feed.push_back(cs ^ (8'd1 << $urandom_range(0, 7)));
      exp_err++;
    end else begin
      rx_feed.push_back(cs);
      it.len  = 4'(len);
      it.data = m;
      rx_exp.push_back(it);
    end
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5, input int n);
    logic [7:0] v[6];
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3; v[4] = b4; v[5] = b5;
    for (int i = 0; i < n; i++) rx_feed.push_back(v[i]);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((tx_exp.size() != 0 || rx_feed.size() != 0 || rx_exp.size() != 0 ||
            uart_send_flag || uart_recv_flag) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) fail_now("drain_timeout");
    repeat (6) @(negedge clk);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    int len, kind;
    tx_valid = 1'b0; tx_data = 64'd0; tx_len = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx_ready", 64'(tx_ready), 64'd0);
    chk("reset_rx_valid", 64'(rx_valid), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_send_flag", 64'(uart_send_flag), 64'd0);
    chk("reset_recv_flag", 64'(uart_recv_flag), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tx_ready_after_reset", 64'(tx_ready), 64'd1);

    // T1: fixed 3-byte word
    send_word(64'h1122334455667788, 4'd3);
    wait_idle();
    chk("t1_tx_ready_back", 64'(tx_ready), 64'd1);

    // T5: no send requests while uart_comm is full
    block_send = 1;
    send_word(64'h1122334455667788, 4'd3);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (uart_send_flag) seen = 1;
    end
    chk("t5_no_send_flag_when_full", 64'(seen), 64'd0);
    block_send = 0;
    wait_idle();

    // T2: received word held under backpressure, no reads while holding
    rx_hold = 1;
    feed_frame(64'h1234, 2, 0, 0);
    feed_frame({$urandom, $urandom}, 4, 0, 0);
    seen = 0;
    for (int c = 0; c < 2000 && !rx_valid; c++) @(negedge clk);
    chk("t2_rx_valid", 64'(rx_valid), 64'd1);
    chk("t2_rx_len", 64'(rx_len), 64'd2);
    chk("t2_rx_data", rx_data, 64'h1234);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (uart_recv_flag) seen = 1;
    end
    chk("t2_no_recv_flag_in_hold", 64'(seen), 64'd0);
    chk("t2_still_valid", 64'(rx_valid), 64'd1);
    rx_hold = 0;
    wait_idle();

    // T3: junk then bad checksum, then a good frame
    push_bytes(8'h00, SYNC, 8'h02, 8'h34, 8'h12, 8'h25, 6);
    exp_err++;
    feed_frame({$urandom, $urandom}, 3, 0, 0);
    wait_idle();
    chk("t3_err_count", 64'(err_count), 64'(exp_err));

    // T4: length error, then inter-byte timeout
    push_bytes(SYNC, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    exp_err++;
    wait_idle();
    chk("t4_len_err_count", 64'(err_count), 64'(exp_err));
    push_bytes(SYNC, 8'h02, 8'h34, 8'h00, 8'h00, 8'h00, 3);
    wait_idle();
    repeat (TMO + 20) @(negedge clk);
    exp_err++;
    chk("t4_timeout_err_count", 64'(err_count), 64'(exp_err));
    feed_frame({$urandom, $urandom}, 5, 0, 1);
    wait_idle();

    // Timeout with a read outstanding: its byte (a SYNC value) must be discarded
    push_bytes(SYNC, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    wait_idle();
    rx_stall = 1;
    rx_feed.push_back(SYNC);
    repeat (TMO + 20) @(negedge clk);
    exp_err++;
    chk("timeout_outstanding_err", 64'(err_count), 64'(exp_err));
    rx_stall = 0;
    push_bytes(8'h02, 8'h34, 8'h12, 8'h24, 8'h00, 8'h00, 4);
    feed_frame({$urandom, $urandom}, 8, 0, 0);
    wait_idle();
    chk("timeout_outstanding_err_after", 64'(err_count), 64'(exp_err));

    // Randomised traffic, TX and RX concurrently
    for (int n = 0; n < 40; n++) begin
      len  = $urandom_range(1, MAX_LEN);
      kind = $urandom_range(0, 9);
      kind = (kind < 7) ? 0 : (kind < 9) ? 1 : 2;
      if (kind == 2) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15);
      feed_frame({$urandom, $urandom}, len, kind, $urandom_range(0, 2));
      len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15))
                                        : $urandom_range(1, MAX_LEN);
      send_word({$urandom, $urandom}, 4'(len));
    end
    wait_idle();
    chk("random_err_count", 64'(err_count), 64'(exp_err));

    // T6: reset in the middle of a TX and an RX frame
    send_word({$urandom, $urandom}, 4'd8);
    push_bytes(SYNC, 8'h08, 8'h01, 8'h02, 8'h03, 8'h00, 5);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx_ready", 64'(tx_ready), 64'd0);
    chk("t6_rx_valid", 64'(rx_valid), 64'd0);
    chk("t6_rx_data", rx_data, 64'd0);
    chk("t6_rx_len", 64'(rx_len), 64'd0);
    chk("t6_err_count", 64'(err_count), 64'd0);
    chk("t6_send_flag", 64'(uart_send_flag), 64'd0);
    chk("t6_send_data", 64'(uart_send_data), 64'd0);
    chk("t6_recv_flag", 64'(uart_recv_flag), 64'd0);
    tx_exp.delete();
    rx_feed.delete();
    rx_exp.delete();
    exp_err = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed_frame({$urandom, $urandom}, 6, 0, 1);
    send_word({$urandom, $urandom}, 4'd7);
    wait_idle();
    chk("t6_err_after_reset", 64'(err_count), 64'(exp_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
